// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_pkg;
  localparam int NREQ_DEF   = 3;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 64;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester handshake plus register-file write port for rf_wb_arbiter.
// RF_WB_ARB_FWD_EN adds the read-stage forwarding signals.
interface rf_wb_arbiter_if #(
  parameter int NREQ       = rf_wb_pkg::NREQ_DEF,
  parameter int ADDR_WIDTH = rf_wb_pkg::ADDR_W_DEF,
  parameter int DATA_WIDTH = rf_wb_pkg::DATA_W_DEF
);
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NREQ-1:0][DATA_WIDTH-1:0] req_data;
  logic                            stall;
  logic                            rf_wen;
  logic [ADDR_WIDTH-1:0]           rf_waddr;
  logic [DATA_WIDTH-1:0]           rf_wdata;
  logic [$clog2(NREQ)-1:0]         grant_id;
`ifdef RF_WB_ARB_FWD_EN
  logic [ADDR_WIDTH-1:0]           fwd_raddr;
  logic                            fwd_hit;
  logic [DATA_WIDTH-1:0]           fwd_data;

  modport master (output req_valid, req_addr, req_data, stall, fwd_raddr,
                  input  req_ready, rf_wen, rf_waddr, rf_wdata, grant_id, fwd_hit, fwd_data);
  modport slave  (input  req_valid, req_addr, req_data, stall, fwd_raddr,
                  output req_ready, rf_wen, rf_waddr, rf_wdata, grant_id, fwd_hit, fwd_data);
`else
  modport master (output req_valid, req_addr, req_data, stall,
                  input  req_ready, rf_wen, rf_waddr, rf_wdata, grant_id);
  modport slave  (input  req_valid, req_addr, req_data, stall,
                  output req_ready, rf_wen, rf_waddr, rf_wdata, grant_id);
`endif
endinterface

// File: rtl/rf_wb_arbiter_rr_picker.sv
// Combinational round-robin selector: first valid at or after ptr, wrapping.
module rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !found && valid[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters.
// Define RF_WB_ARB_FWD_EN to add a combinational write-to-read bypass.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         idx;
  logic                  pick_en;
  logic                  xfer;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;

  // Gating on rst keeps ready low for the whole time reset is held.
  assign pick_en = !bus.stall && !rst;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .en    (pick_en),
    .gnt   (gnt),
    .idx   (idx)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    xfer       = |gnt;
    ptr_d      = ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    if (xfer) begin
      ptr_d      = (32'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
      // x0 writes are consumed but never reach the register file.
      rf_wen_d   = bus.req_addr[idx] != ADDR_WIDTH'(REG_ZERO);
      rf_waddr_d = bus.req_addr[idx];
      rf_wdata_d = bus.req_data[idx];
      grant_id_d = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.grant_id = grant_id_q;

`ifdef RF_WB_ARB_FWD_EN
  assign bus.fwd_hit  = rf_wen_q && (rf_waddr_q == bus.fwd_raddr) &&
                        (bus.fwd_raddr != ADDR_WIDTH'(REG_ZERO));
  assign bus.fwd_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter (NREQ=3); covers RF_WB_ARB_FWD_EN when defined.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  typedef struct packed {
    logic       wen;
    wb_req_t    req;
    logic [1:0] gid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t last;

  rf_wb_arbiter_if #(.NREQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  rf_wb_arbiter #(.NREQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
    bus.req_addr[i] = a;
    bus.req_data[i] = d;
  endtask

  // One clock: drive, check the combinational grant, push the expected write,
  // then compare the registered port against the popped entry.
  task automatic cyc(input logic [2:0] v, input logic st, input logic [2:0] rdy);
    exp_t e;
    exp_t got;
    bus.req_valid = v;
    bus.stall     = st;
    #2;
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    e     = last;
    e.wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rdy[i]) begin
        e.req.addr = bus.req_addr[i];
        e.req.data = bus.req_data[i];
        e.gid      = 2'(i);
        e.wen      = (bus.req_addr[i] != REG_ZERO);
      end
    end
    q.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("rf_wen",   64'(bus.rf_wen),   64'(got.wen));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(got.req.addr));
    chk("rf_wdata", bus.rf_wdata,      got.req.data);
    chk("grant_id", 64'(bus.grant_id), 64'(got.gid));
  endtask

`ifdef RF_WB_ARB_FWD_EN
  task automatic fwd_chk(input logic [4:0] ra, input logic hit, input logic [63:0] d);
    bus.fwd_raddr = ra;
    #1;
    chk("fwd_hit", 64'(bus.fwd_hit), 64'(hit));
    if (hit) chk("fwd_data", bus.fwd_data, d);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.stall     = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
`ifdef RF_WB_ARB_FWD_EN
    bus.fwd_raddr = '0;
`endif
    last = '0;

    // Reset state, with all requesters valid: nothing may be granted.
    @(posedge clk);
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_wen",   64'(bus.rf_wen),    64'(0));
    chk("rst_waddr", 64'(bus.rf_waddr),  64'(0));
    chk("rst_wdata", bus.rf_wdata,       64'(0));
    chk("rst_gid",   64'(bus.grant_id),  64'(0));
    rst           = 1'b0;
    bus.req_valid = '0;
    @(posedge clk);
    #1;

    cyc(3'b000, 1'b0, 3'b000);

    // Single request from requester 0.
    set_req(0, 5'd5, 64'hDEAD);
    cyc(3'b001, 1'b0, 3'b001);

    // Reset mid-cycle while that write is on the port.
    bus.req_valid = 3'b111;
    rst = 1'b1;
    #1;
    chk("mid_rst_wen",   64'(bus.rf_wen),    64'(0));
    chk("mid_rst_waddr", 64'(bus.rf_waddr),  64'(0));
    chk("mid_rst_gid",   64'(bus.grant_id),  64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    last = '0;
    q.delete();
    #1;
    rst = 1'b0;
    cyc(3'b000, 1'b0, 3'b000);

    // All three held valid from ptr=0: strict rotation.
    set_req(0, 5'd1, 64'h100);
    set_req(1, 5'd2, 64'h200);
    set_req(2, 5'd4, 64'h400);
    cyc(3'b111, 1'b0, 3'b001);
    cyc(3'b111, 1'b0, 3'b010);
    cyc(3'b111, 1'b0, 3'b100);
    cyc(3'b111, 1'b0, 3'b001);
    cyc(3'b111, 1'b0, 3'b010);
    cyc(3'b111, 1'b0, 3'b100);

    // Stall blocks requester 1 for two cycles.
    cyc(3'b010, 1'b1, 3'b000);
    cyc(3'b010, 1'b1, 3'b000);
    cyc(3'b010, 1'b0, 3'b010);

    // Write to x0 is consumed without enabling the write; then a normal one.
    set_req(2, 5'd0, 64'h1234);
    cyc(3'b100, 1'b0, 3'b100);
    set_req(2, 5'd3, 64'h55);
    cyc(3'b100, 1'b0, 3'b100);

    // Move ptr to 1, then both 0 and 1 target x7.
    set_req(0, 5'd9, 64'h99);
    cyc(3'b001, 1'b0, 3'b001);
    set_req(0, 5'd7, 64'h11);
    set_req(1, 5'd7, 64'h22);
    cyc(3'b011, 1'b0, 3'b010);
`ifdef RF_WB_ARB_FWD_EN
    fwd_chk(5'd7, 1'b1, 64'h22);
    fwd_chk(5'd0, 1'b0, 64'h0);
`endif
    cyc(3'b001, 1'b0, 3'b001);
`ifdef RF_WB_ARB_FWD_EN
    fwd_chk(5'd7, 1'b1, 64'h11);
    fwd_chk(5'd0, 1'b0, 64'h0);
`endif
    cyc(3'b000, 1'b0, 3'b000);
`ifdef RF_WB_ARB_FWD_EN
    fwd_chk(5'd7, 1'b0, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) between NREQ writeback requesters, e.g. ALU, LSU and CSR unit.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Drives the register-file write port from registered outputs.
- Sits between the execute/writeback stages and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 64, write data width.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant/accept, one-hot or zero, combinational.
- req_addr  in  NREQ*ADDR_WIDTH  destination register; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NREQ*DATA_WIDTH  write data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- stall  in  1  blocks all grants this cycle.
- rf_wen  out  1  register-file write enable, registered.
- rf_waddr  out  ADDR_WIDTH  register-file write address, registered.
- rf_wdata  out  DATA_WIDTH  register-file write data, registered.
- grant_id  out  $clog2(NREQ)  index of the requester that produced the current rf_* outputs, registered.

Behaviour:
- Reset (async, rst=1):
  - ptr=0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0.
  - req_ready=0 while rst is asserted.
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 only when stall=0 and at least one valid is set; all other ready bits are 0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester must hold valid/addr/data stable until it is accepted.
  - req_ready may depend on req_valid; valid must not depend on ready.
- Latency: a transfer accepted in cycle N appears on rf_wen/rf_waddr/rf_wdata/grant_id in cycle N+1. Exactly one write per cycle maximum.
- Pointer: on a transfer, ptr <= (winner+1) mod NREQ. With no transfer, ptr holds.
- Starvation bound: a continuously valid requester is accepted within NREQ cycles of stall being 0.
- x0 handling:
  - A transfer with addr==0 is accepted and the pointer advances, but next cycle rf_wen=0.
  - rf_waddr/rf_wdata still update to the accepted values; grant_id updates.
- No transfer in cycle N (no valid, or stall=1): rf_wen=0 in N+1; rf_waddr/rf_wdata/grant_id hold their previous values.
- Same destination from two requesters in the same cycle: only the winner is accepted. The loser is written in a later cycle, so the last write in round-robin order wins. There is no merging.
- Reset asserted mid-operation: the pending registered write is discarded (rf_wen forced to 0 immediately) and ptr returns to 0.

Optional Feature:
- Macro: RF_WB_ARB_FWD_EN.
- Defined:
  - Adds input fwd_raddr (ADDR_WIDTH) and outputs fwd_hit (1) and fwd_data (DATA_WIDTH), all combinational.
  - fwd_hit = rf_wen && rf_waddr==fwd_raddr && fwd_raddr!=0; fwd_data = rf_wdata.
  - Lets the read stage bypass the one-cycle register-file write latency.
- Undefined: these ports do not exist; the behaviour of everything else is identical.

Decomposition:
- Package rf_wb_pkg holds:
  - default NREQ, ADDR_WIDTH and DATA_WIDTH constants;
  - REG_ZERO constant (0);
  - a typedef for a writeback request (addr, data).
- Sub-module rr_picker:
  - pure combinational round-robin selector;
  - inputs: valid vector, ptr, enable;
  - outputs: one-hot grant and encoded index.
- The arbiter instantiates one rr_picker plus the ptr and output registers.

Test Plan:
- Reset sequence: rst=1 mid-cycle with a write pending -> rf_wen=0 immediately, ptr=0; after release with no valid, rf_wen stays 0.
- Single request: req0 addr=5 data=0xDEAD for 1 cycle -> req_ready=001 in cycle N; rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD, grant_id=0 in N+1.
- All three requesters held valid for 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2; rf_wen=1 every cycle after the first.
- stall=1 for 2 cycles with req1 valid -> req_ready=000 and rf_wen=0 for those cycles; req1 is accepted on the first cycle with stall=0.
- Write to x0: req2 addr=0 data=0x1234 -> accepted and ptr advances, rf_wen=0 next cycle; a subsequent req2 addr=3 is written normally.
- Same-address conflict: req0 and req1 both target addr=7 (data 0x11/0x22) from ptr=1 -> 0x22 written first, then 0x11; final x7=0x11. With the macro defined, fwd_raddr=7 shows fwd_hit=1 in each write cycle, and fwd_raddr=0 gives fwd_hit=0.
